// File: rtl/mem_port_arbiter_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : mem_port_arbiter_if                                              |
// | Brief   : Fetch, data and memory-side signal bundle for mem_port_arbiter.  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
interface mem_port_arbiter_if;
    logic        i_req;
    logic [15:0] i_address;
    logic        i_abort;
    logic [15:0] i_rdata;
    logic        i_done;
    logic        i_stall;

    logic        d_req;
    logic        d_we;
    logic [15:0] d_address;
    logic [15:0] d_wdata;
    logic [15:0] d_rdata;
    logic        d_done;
    logic        d_stall;

    logic        m_readM;
    logic        m_writeM;
    logic [15:0] m_address;
    logic [15:0] m_wdata;
    logic [15:0] m_rdata;

    // Arbiter side
    modport slave (
        input  i_req, i_address, i_abort,
        output i_rdata, i_done, i_stall,
        input  d_req, d_we, d_address, d_wdata,
        output d_rdata, d_done, d_stall,
        output m_readM, m_writeM, m_address, m_wdata,
        input  m_rdata
    );

    // Requester / memory-model side
    modport master (
        output i_req, i_address, i_abort,
        input  i_rdata, i_done, i_stall,
        output d_req, d_we, d_address, d_wdata,
        input  d_rdata, d_done, d_stall,
        input  m_readM, m_writeM, m_address, m_wdata,
        output m_rdata
    );
endinterface
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : mem_port_arbiter                                                 |
// | Brief   : Fetch/data arbiter for a single-ported multi-cycle memory.       |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module mem_port_arbiter #(
    parameter int MEM_LATENCY  = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  wire logic            clk,
    input  wire logic            rst,
    mem_port_arbiter_if.slave    bus
);

    localparam logic [3:0] c_LAT_LOAD     = 4'(MEM_LATENCY - 1);
    localparam logic [3:0] c_STARVE_LIMIT = 4'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_I_ACC = 2'd1,
        S_D_ACC = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_state_next;
    logic [3:0]  r_lat_cnt;
    logic [3:0]  r_starve_cnt;
    logic        r_abort;
    logic        r_owner_d;
    logic        r_we;
    logic [15:0] r_address;
    logic [15:0] r_wdata;
    logic [15:0] r_i_rdata;
    logic [15:0] r_d_rdata;

    logic        w_force_i;
    logic        w_grant_d;
    logic        w_grant_i;
    logic        w_last;

    always_comb begin
        w_state_next = r_state;
        w_force_i    = bus.i_req & (r_starve_cnt == c_STARVE_LIMIT);
        w_grant_d    = 1'b0;
        w_grant_i    = 1'b0;
        w_last       = (r_lat_cnt == 4'd0);
        case (r_state)
            S_IDLE: begin
                // Data side wins ties unless fetch has waited too long
                if (bus.d_req && !w_force_i) begin
                    w_grant_d    = 1'b1;
                    w_state_next = S_D_ACC;
                end else if (bus.i_req) begin
                    w_grant_i    = 1'b1;
                    w_state_next = S_I_ACC;
                end
            end
            S_I_ACC, S_D_ACC: begin
                if (w_last) begin
                    w_state_next = S_RESP;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_lat_cnt    <= 4'd0;
            r_starve_cnt <= 4'd0;
            r_abort      <= 1'b0;
            r_owner_d    <= 1'b0;
            r_we         <= 1'b0;
            r_address    <= 16'd0;
            r_wdata      <= 16'd0;
            r_i_rdata    <= 16'd0;
            r_d_rdata    <= 16'd0;
        end else begin
            r_state <= w_state_next;

            if (w_grant_d || w_grant_i) begin
                r_address <= w_grant_d ? bus.d_address : bus.i_address;
                r_wdata   <= w_grant_d ? bus.d_wdata : r_wdata;
                r_we      <= w_grant_d & bus.d_we;
                r_owner_d <= w_grant_d;
                r_lat_cnt <= c_LAT_LOAD;
                r_abort   <= 1'b0;
            end

            if (r_state == S_IDLE) begin
                if (w_grant_i || !bus.i_req) begin
                    r_starve_cnt <= 4'd0;
                end else if (w_grant_d && (r_starve_cnt < c_STARVE_LIMIT)) begin
                    r_starve_cnt <= r_starve_cnt + 4'd1;
                end
            end

            if ((r_state == S_I_ACC) || (r_state == S_D_ACC)) begin
                if (!w_last) begin
                    r_lat_cnt <= r_lat_cnt - 4'd1;
                end
                if ((r_state == S_I_ACC) && bus.i_abort) begin
                    r_abort <= 1'b1;
                end
                // A flush arriving in the final cycle still suppresses the fetch result
                if (w_last) begin
                    if ((r_state == S_I_ACC) && !(r_abort || bus.i_abort)) begin
                        r_i_rdata <= bus.m_rdata;
                    end
                    if ((r_state == S_D_ACC) && !r_we) begin
                        r_d_rdata <= bus.m_rdata;
                    end
                end
            end
        end
    end

    assign bus.m_address = r_address;
    assign bus.m_wdata   = r_wdata;
    assign bus.m_readM   = (r_state == S_I_ACC) | ((r_state == S_D_ACC) & ~r_we);
    assign bus.m_writeM  = (r_state == S_D_ACC) & r_we;
    assign bus.i_done    = (r_state == S_RESP) & ~r_owner_d & ~r_abort;
    assign bus.d_done    = (r_state == S_RESP) & r_owner_d;
    assign bus.i_rdata   = r_i_rdata;
    assign bus.d_rdata   = r_d_rdata;
    assign bus.i_stall   = bus.i_req & ~bus.i_done;
    assign bus.d_stall   = bus.d_req & ~bus.d_done;

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_mem_port_arbiter                                              |
// | Brief   : Directed vector bench for mem_port_arbiter.                      |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_mem_port_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    mem_port_arbiter_if bus ();
    mem_port_arbiter_if bus1 ();

    mem_port_arbiter #(.MEM_LATENCY(2), .STARVE_LIMIT(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    mem_port_arbiter #(.MEM_LATENCY(1), .STARVE_LIMIT(4)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1)
    );

    typedef struct {
        logic        we;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [15:0] mrdata;
        logic [15:0] exp_rdata;
    } dvec_t;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One data access on the MEM_LATENCY=2 instance, checked cycle by cycle
    task automatic d_access(input dvec_t v);
        @(negedge clk);
        bus.d_req = 1'b1; bus.d_we = v.we; bus.d_address = v.addr;
        bus.d_wdata = v.wdata; bus.m_rdata = 16'hDEAD;
        #1 check("d_stall_c0", 16'(bus.d_stall), 16'd1);
        for (int k = 1; k <= 2; k++) begin
            @(negedge clk);
            if (k == 2) bus.m_rdata = v.mrdata;
            check("d_readM", 16'(bus.m_readM), 16'(!v.we));
            check("d_writeM", 16'(bus.m_writeM), 16'(v.we));
            check("d_maddr", bus.m_address, v.addr);
            if (v.we) check("d_mwdata", bus.m_wdata, v.wdata);
            check("d_done_early", 16'(bus.d_done), 16'd0);
        end
        @(negedge clk);
        bus.m_rdata = 16'hDEAD;
        check("d_done", 16'(bus.d_done), 16'd1);
        check("d_rdata", bus.d_rdata, v.exp_rdata);
        check("d_strobes_resp", 16'({bus.m_readM, bus.m_writeM}), 16'd0);
        check("d_stall_done", 16'(bus.d_stall), 16'd0);
        check("i_done_in_d", 16'(bus.i_done), 16'd0);
        bus.d_req = 1'b0;
        @(negedge clk);
        check("d_done_after", 16'(bus.d_done), 16'd0);
        check("d_idle_strobes", 16'({bus.m_readM, bus.m_writeM}), 16'd0);
    endtask

    task automatic fetch(input logic [15:0] addr, input logic [15:0] mrd, input logic do_abort,
                         input logic exp_done, input logic [15:0] exp_rdata);
        @(negedge clk);
        bus.i_req = 1'b1; bus.i_address = addr; bus.m_rdata = 16'hDEAD;
        #1 check("i_stall_c0", 16'(bus.i_stall), 16'd1);
        @(negedge clk);
        check("i_readM_c1", 16'(bus.m_readM), 16'd1);
        check("i_maddr", bus.m_address, addr);
        if (do_abort) bus.i_abort = 1'b1;
        @(negedge clk);
        bus.i_abort = 1'b0; bus.m_rdata = mrd;
        check("i_readM_c2", 16'(bus.m_readM), 16'd1);
        @(negedge clk);
        bus.m_rdata = 16'hDEAD;
        check("i_done", 16'(bus.i_done), 16'(exp_done));
        check("i_rdata", bus.i_rdata, exp_rdata);
        check("i_readM_c3", 16'(bus.m_readM), 16'd0);
        bus.i_req = 1'b0;
        @(negedge clk);
        check("i_done_after", 16'(bus.i_done), 16'd0);
    endtask

    dvec_t vecs [5];
    logic  exp_seq [6];
    logic  got_seq [6];

    initial begin
        vecs[0] = '{we: 1'b0, addr: 16'h0010, wdata: 16'h0000, mrdata: 16'hBEEF, exp_rdata: 16'hBEEF};
        vecs[1] = '{we: 1'b1, addr: 16'h0020, wdata: 16'h1234, mrdata: 16'h9999, exp_rdata: 16'hBEEF};
        vecs[2] = '{we: 1'b0, addr: 16'h00FF, wdata: 16'h4444, mrdata: 16'h0000, exp_rdata: 16'h0000};
        vecs[3] = '{we: 1'b1, addr: 16'hFFFF, wdata: 16'hA5A5, mrdata: 16'h1111, exp_rdata: 16'h0000};
        vecs[4] = '{we: 1'b0, addr: 16'h8000, wdata: 16'h0000, mrdata: 16'hFFFF, exp_rdata: 16'hFFFF};
        exp_seq = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};

        bus.i_req = 0; bus.i_address = 0; bus.i_abort = 0;
        bus.d_req = 0; bus.d_we = 0; bus.d_address = 0; bus.d_wdata = 0; bus.m_rdata = 0;
        bus1.i_req = 0; bus1.i_address = 0; bus1.i_abort = 0;
        bus1.d_req = 0; bus1.d_we = 0; bus1.d_address = 0; bus1.d_wdata = 0; bus1.m_rdata = 0;

        repeat (2) @(negedge clk);
        check("rst_strobes", 16'({bus.m_readM, bus.m_writeM}), 16'd0);
        check("rst_dones", 16'({bus.i_done, bus.d_done}), 16'd0);
        check("rst_maddr", bus.m_address, 16'd0);
        check("rst_mwdata", bus.m_wdata, 16'd0);
        check("rst_i_rdata", bus.i_rdata, 16'd0);
        check("rst_d_rdata", bus.d_rdata, 16'd0);
        rst = 1'b0;

        for (int i = 0; i < 5; i++) d_access(vecs[i]);

        // Both sides held: D wins four times, then fetch is forced
        begin
            int n_ev = 0;
            int cyc  = 0;
            @(negedge clk);
            bus.i_req = 1; bus.i_address = 16'h0100;
            bus.d_req = 1; bus.d_we = 0; bus.d_address = 16'h0200; bus.m_rdata = 16'h7777;
            while (n_ev < 6 && cyc < 100) begin
                @(negedge clk);
                cyc++;
                if (bus.i_done && bus.d_done) check("both_done", 16'd1, 16'd0);
                else if (bus.i_done || bus.d_done) begin
                    got_seq[n_ev] = bus.d_done;
                    n_ev++;
                end
            end
            bus.i_req = 0; bus.d_req = 0;
            check("starve_timeout", 16'(n_ev), 16'd6);
            for (int i = 0; i < 6; i++) check("starve_seq", 16'(got_seq[i]), 16'(exp_seq[i]));
            check("starve_i_rdata", bus.i_rdata, 16'h7777);
            @(negedge clk);
        end

        fetch(16'h0005, 16'h4321, 1'b1, 1'b0, 16'h7777);
        fetch(16'h0006, 16'h1111, 1'b0, 1'b1, 16'h1111);

        // Reset during the first access cycle of a load
        @(negedge clk);
        bus.d_req = 1; bus.d_we = 0; bus.d_address = 16'h0300;
        @(negedge clk);
        check("mid_readM", 16'(bus.m_readM), 16'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0; bus.d_req = 0;
        check("mid_rst_strobes", 16'({bus.m_readM, bus.m_writeM}), 16'd0);
        check("mid_rst_dones", 16'({bus.i_done, bus.d_done}), 16'd0);
        check("mid_rst_maddr", bus.m_address, 16'd0);
        check("mid_rst_i_rdata", bus.i_rdata, 16'd0);
        check("mid_rst_d_rdata", bus.d_rdata, 16'd0);
        @(negedge clk);
        check("mid_rst_no_done", 16'(bus.d_done), 16'd0);
        d_access('{we: 1'b0, addr: 16'h0040, wdata: 16'h0000, mrdata: 16'h5A5A, exp_rdata: 16'h5A5A});

        // Single-cycle latency fetch
        @(negedge clk);
        bus1.i_req = 1; bus1.i_address = 16'h0009;
        #1 check("l1_stall_c0", 16'(bus1.i_stall), 16'd1);
        @(negedge clk);
        check("l1_readM_c1", 16'(bus1.m_readM), 16'd1);
        check("l1_stall_c1", 16'(bus1.i_stall), 16'd1);
        check("l1_done_c1", 16'(bus1.i_done), 16'd0);
        bus1.m_rdata = 16'hCAFE;
        @(negedge clk);
        bus1.m_rdata = 16'h0000;
        check("l1_readM_c2", 16'(bus1.m_readM), 16'd0);
        check("l1_done_c2", 16'(bus1.i_done), 16'd1);
        check("l1_rdata", bus1.i_rdata, 16'hCAFE);
        check("l1_stall_c2", 16'(bus1.i_stall), 16'd0);
        bus1.i_req = 0;
        @(negedge clk);
        check("l1_done_c3", 16'(bus1.i_done), 16'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares one single-ported, multi-cycle unified memory between the pipelined CPU's instruction-fetch side and data side. Sits between the datapath's fetch/MEM-stage memory requests and the memory model. A counter-timed FSM sequences each access, returns a one-cycle done pulse with registered read data, and produces the stall signals that freeze the pipeline. Data side has priority; a starvation guard bounds fetch wait.

## Interface
- MEM_LATENCY, 2, cycles each access holds the memory port; legal 1..15
- STARVE_LIMIT, 4, consecutive D grants with i_req pending before I is forced; legal 1..15
- Clk  in  1  clock, all state updates on rising edge
- Reset  in  1  synchronous, active-high reset
- i_req  in  1  fetch request; held with i_address until i_done
- i_address  in  16  fetch address
- i_abort  in  1  flush: discard in-flight fetch result
- i_rdata  out  16  fetched word, valid while i_done=1
- i_done  out  1  one-cycle fetch completion pulse
- i_stall  out  1  i_req & ~i_done
- d_req  in  1  data request; held with d_we/d_address/d_wdata until d_done
- d_we  in  1  1 = store, 0 = load
- d_address  in  16  data address
- d_wdata  in  16  store data
- d_rdata  out  16  load data, valid while d_done=1
- d_done  out  1  one-cycle data completion pulse
- d_stall  out  1  d_req & ~d_done
- m_readM  out  1  memory read strobe
- m_writeM  out  1  memory write strobe
- m_address  out  16  memory address
- m_wdata  out  16  memory write data (top level drives tristate bus)
- m_rdata  in  16  memory read data, valid in last access cycle

## Operation
- States: IDLE, I_ACC, D_ACC, RESP.
- IDLE: d_req and not forced-I → D_ACC; else i_req → I_ACC; else stay. Forced-I = i_req & (starve_cnt == STARVE_LIMIT).
- On grant: latch address, wdata, we, owner; load lat_cnt = MEM_LATENCY-1; clear abort flag.
- I_ACC/D_ACC: m_address/m_wdata from latches; m_readM = (I_ACC) | (D_ACC & ~we_latched); m_writeM = D_ACC & we_latched. lat_cnt decrements; at lat_cnt==0, capture m_rdata into owner's rdata register, → RESP.
- RESP: owner's done = 1 (I owner: only if abort flag clear). Requests ignored; → IDLE.
- Store: d_done pulses; d_rdata holds previous value.
- i_abort sampled in I_ACC sets abort flag; memory access still completes (no partial cycles); i_done suppressed, i_rdata not updated. i_abort in any other state ignored.
- starve_cnt (4 bit): +1 on each D grant while i_req=1, saturating at STARVE_LIMIT; cleared on any I grant or when i_req=0 in IDLE.
- m_* and done outputs derive only from registers; only combinational req→output paths are i_stall/d_stall.

## Timing
- Reset: state IDLE; m_readM, m_writeM, i_done, d_done = 0; m_address, m_wdata, i_rdata, d_rdata, lat_cnt, starve_cnt, abort flag = 0. Reset mid-access abandons it; strobes low from next cycle.
- Request seen in IDLE at cycle 0 → strobes cycles 1..MEM_LATENCY → done at cycle MEM_LATENCY+1 → IDLE at MEM_LATENCY+2. Back-to-back period MEM_LATENCY+2.
- Simultaneous i_req/d_req in IDLE: D wins unless forced-I.
- Requester may change or drop req the cycle after done; req dropped before done is a protocol violation (access still completes, done still pulses).
- Exactly one done per grant; never both dones in one cycle.

## Test plan
- Single load, MEM_LATENCY=2, d_address=0x0010, m_rdata=0xBEEF on cycle 2 → m_readM cycles 1–2, d_done=1 with d_rdata=0xBEEF cycle 3, IDLE cycle 4.
- Store d_address=0x0020, d_wdata=0x1234 → m_writeM=1, m_readM=0 cycles 1–2, m_wdata=0x1234; d_done cycle 3; d_rdata unchanged.
- i_req and d_req both held continuously, STARVE_LIMIT=4 → grants D,D,D,D,I,D… ; i_done after exactly 4 D completions.
- Fetch 0x0005, i_abort pulse cycle 1 → m_readM still cycles 1–2, i_done stays 0, i_rdata unchanged; next fetch proceeds normally.
- Reset asserted cycle 1 of a D_ACC → strobes 0 cycle 2, no d_done, all outputs at reset values; later request starts fresh.
- MEM_LATENCY=1 fetch with i_req only → m_readM cycle 1 only, i_done cycle 2, i_stall=1 cycles 0–1 and 0 cycle 2.
